// File: rtl/revo_decoder.sv
// revo_decoder: oversampled revo-on-clock receiver with lock tracking, revo strobe and link statistics
module revo_decoder #(
  parameter int OVERSAMPLE     = 4,
  parameter int NORMAL_LOW_MAX = OVERSAMPLE - 1,
  parameter int MARKER_LOW_MIN = 5,
  parameter int MARKER_LOW_MAX = 7,
  parameter int HIGH_MIN       = 1,
  parameter int HIGH_MAX       = OVERSAMPLE - 1,
  parameter int TIMEOUT        = 16,
  parameter int LOCK_EDGES     = 16,
  parameter int PERIOD_WIDTH   = 24,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    encoded,
  output logic                    revo,
  output logic                    locked,
  output logic [COUNT_WIDTH-1:0]  revo_count,
  output logic [PERIOD_WIDTH-1:0] revo_period,
  output logic                    period_valid,
  output logic [COUNT_WIDTH-1:0]  error_count
);
  localparam logic [7:0] NL_MAX  = 8'(NORMAL_LOW_MAX);
  localparam logic [7:0] M_MIN   = 8'(MARKER_LOW_MIN);
  localparam logic [7:0] M_MAX   = 8'(MARKER_LOW_MAX);
  localparam logic [7:0] H_MIN   = 8'(HIGH_MIN);
  localparam logic [7:0] H_MAX   = 8'(HIGH_MAX);
  localparam logic [7:0] TO_M1   = 8'(TIMEOUT - 1);
  localparam logic [7:0] LOCK_M1 = 8'(LOCK_EDGES - 1);
  typedef enum logic [1:0] {LOST, ACQUIRE, LOCKED} state_t;
  state_t state;
  logic s_meta, s, s_d;
  logic [7:0] low_run, high_run, good_cnt;
  logic rise, fall, good, marker, bad, timeout, have_revo;
  logic [PERIOD_WIDTH-1:0] since_revo;
  // Edge detection and run classification of the synchronized line
  always_comb begin
    rise    = s & ~s_d;
    fall    = ~s & s_d;
    good    = (rise & low_run >= 8'd1 & low_run <= NL_MAX) | (fall & high_run >= H_MIN & high_run <= H_MAX);
    marker  = rise & low_run >= M_MIN & low_run <= M_MAX;
    bad     = (rise | fall) & ~good & ~marker;
    timeout = (~s & ~s_d & low_run == TO_M1) | (s & s_d & high_run == TO_M1);
  end
  // Two-flop synchronizer, delay flop and saturating run-length counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_meta   <= 1'b0;
      s        <= 1'b0;
      s_d      <= 1'b0;
      low_run  <= '0;
      high_run <= '0;
    end else begin
      s_meta   <= encoded;
      s        <= s_meta;
      s_d      <= s;
      low_run  <= fall ? 8'd1 : (~s && low_run != 8'hff) ? low_run + 8'd1 : low_run;
      high_run <= rise ? 8'd1 : (s && high_run != 8'hff) ? high_run + 8'd1 : high_run;
    end
  end
  // Lock state machine with revo strobe, counters and revo period measurement
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= LOST;
      good_cnt     <= '0;
      revo         <= 1'b0;
      locked       <= 1'b0;
      have_revo    <= 1'b0;
      revo_count   <= '0;
      revo_period  <= '0;
      period_valid <= 1'b0;
      error_count  <= '0;
      since_revo   <= '0;
    end else begin
      revo <= 1'b0;
      if (since_revo != '1) since_revo <= since_revo + PERIOD_WIDTH'(1);
      case (state)
        LOST:
          if (rise) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        ACQUIRE:
          if (good || marker) begin
            good_cnt <= good_cnt + 8'd1;
            if (good_cnt == LOCK_M1) begin
              state      <= LOCKED;
              locked     <= 1'b1;
              since_revo <= '0;
              have_revo  <= 1'b0;
            end
          end else if (bad || timeout) good_cnt <= '0;
        LOCKED:
          if (marker) begin
            revo         <= 1'b1;
            revo_count   <= revo_count + COUNT_WIDTH'(1);
            revo_period  <= (since_revo == '1) ? '1 : since_revo + PERIOD_WIDTH'(1);
            since_revo   <= '0;
            have_revo    <= 1'b1;
            period_valid <= period_valid | have_revo;
          end else if (bad || timeout) begin
            state        <= LOST;
            locked       <= 1'b0;
            period_valid <= 1'b0;
            error_count  <= (error_count == '1) ? error_count : error_count + COUNT_WIDTH'(1);
          end
        default: state <= LOST;
      endcase
    end
  end
endmodule

// File: tb/tb_revo_decoder.sv
// tb_revo_decoder: randomized and directed checks of revo_decoder against a run-length reference model
module tb_revo_decoder;
  logic clock = 1'b0;
  logic reset, encoded;
  logic revo, locked, period_valid;
  logic [15:0] revo_count, error_count;
  logic [23:0] revo_period;
  int checks = 0, failures = 0;
  localparam int LOST = 0, ACQ = 1, LOCK = 2;
  int ha, hb, prev, run, st, gc, ref_m, have, m;
  int e_revo, e_locked, e_cnt, e_per, e_pv, e_err;
  int mism, revo_seen;
  string first_mism;

  revo_decoder dut (
    .clock(clock), .reset(reset), .encoded(encoded), .revo(revo), .locked(locked),
    .revo_count(revo_count), .revo_period(revo_period), .period_valid(period_valid),
    .error_count(error_count)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    ha = 0; hb = 0; prev = 0; run = 0; st = LOST; gc = 0; ref_m = m; have = 0;
    e_revo = 0; e_locked = 0; e_cnt = 0; e_per = 0; e_pv = 0; e_err = 0;
  endtask

  // line sample seen by the classifier lags the pin by two clocks
  task automatic model_step(input logic v);
    int d, ev;
    bit rise_now;
    d = hb; hb = ha; ha = int'(v);
    ev = 0; rise_now = 0;
    if (d != prev) begin
      rise_now = (d == 1);
      if (run >= 1 && run <= 3) ev = 1;
      else if (d == 1 && run >= 5 && run <= 7) ev = 2;
      else ev = 3;
      run = 1;
    end else begin
      if (run < 255) run++;
      if (run == 16) ev = 4;
    end
    prev = d;
    e_revo = 0;
    if (st == LOST) begin
      if (rise_now) begin st = ACQ; gc = 0; end
    end else if (st == ACQ) begin
      if (ev == 1 || ev == 2) begin
        gc++;
        if (gc == 16) begin st = LOCK; ref_m = m; have = 0; end
      end else if (ev >= 3) gc = 0;
    end else begin
      if (ev == 2) begin
        e_revo = 1;
        e_cnt = (e_cnt + 1) % 65536;
        e_per = (m - ref_m > 16777215) ? 16777215 : m - ref_m;
        if (have == 1) e_pv = 1;
        have = 1;
        ref_m = m;
      end else if (ev >= 3) begin
        st = LOST;
        e_err = (e_err < 65535) ? e_err + 1 : e_err;
        e_pv = 0;
      end
    end
    e_locked = (st == LOCK) ? 1 : 0;
  endtask

  task automatic tick(input logic v);
    encoded = v;
    @(posedge clock);
    m++;
    if (reset) model_reset(); else model_step(v);
    #1;
    if (revo === 1'b1) revo_seen++;
    if ({revo, locked, revo_count, revo_period, period_valid, error_count} !==
        {e_revo[0], e_locked[0], e_cnt[15:0], e_per[23:0], e_pv[0], e_err[15:0]}) begin
      if (mism == 0)
        first_mism = $sformatf("cycle %0d got revo=%b locked=%b cnt=%0d per=%0d pv=%b err=%0d want revo=%0d locked=%0d cnt=%0d per=%0d pv=%0d err=%0d",
          m, revo, locked, revo_count, revo_period, period_valid, error_count, e_revo, e_locked, e_cnt, e_per, e_pv, e_err);
      mism++;
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) tick(v);
  endtask

  task automatic carrier(input int k);
    repeat (k) begin drive(1'b0, 2); drive(1'b1, 2); end
  endtask

  task automatic test_reset();
    reset = 1'b1; encoded = 1'b0; m = 0; model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (revo !== 1'b0) begin failures++; $display("FAIL reset_revo got=%b want=0", revo); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
    checks++; if (revo_count !== 16'd0) begin failures++; $display("FAIL reset_revo_count got=%0d want=0", revo_count); end
    checks++; if (revo_period !== 24'd0) begin failures++; $display("FAIL reset_revo_period got=%0d want=0", revo_period); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL reset_period_valid got=%b want=0", period_valid); end
    checks++; if (error_count !== 16'd0) begin failures++; $display("FAIL reset_error_count got=%0d want=0", error_count); end
    reset = 1'b0;
  endtask

  task automatic test_lock();
    mism = 0; revo_seen = 0;
    carrier(10);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%b want=1", locked); end
    checks++; if (revo_seen !== 0) begin failures++; $display("FAIL lock_no_revo got=%0d pulses want=0", revo_seen); end
    checks++; if (error_count !== 16'd0) begin failures++; $display("FAIL lock_error_count got=%0d want=0", error_count); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL lock_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  task automatic test_marker();
    mism = 0; revo_seen = 0;
    drive(1'b0, 6);
    tick(1'b1);
    checks++; if (revo !== 1'b0) begin failures++; $display("FAIL marker_lat1 got=%b want=0", revo); end
    tick(1'b1);
    checks++; if (revo !== 1'b0) begin failures++; $display("FAIL marker_lat2 got=%b want=0", revo); end
    tick(1'b1);
    checks++; if (revo !== 1'b1) begin failures++; $display("FAIL marker_lat3 got=%b want=1", revo); end
    tick(1'b0);
    checks++; if (revo !== 1'b0) begin failures++; $display("FAIL marker_one_cycle got=%b want=0", revo); end
    tick(1'b0); drive(1'b1, 2); carrier(2);
    checks++; if (revo_count !== 16'd1) begin failures++; $display("FAIL marker_count got=%0d want=1", revo_count); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL marker_locked got=%b want=1", locked); end
    checks++; if (revo_seen !== 1) begin failures++; $display("FAIL marker_pulses got=%0d want=1", revo_seen); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL marker_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  task automatic test_period();
    mism = 0;
    drive(1'b0, 6); drive(1'b1, 2); carrier(248);
    drive(1'b0, 6); drive(1'b1, 2); carrier(1);
    checks++; if (revo_period !== 24'd1000) begin failures++; $display("FAIL period_1000 got=%0d want=1000", revo_period); end
    checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL period_valid got=%b want=1", period_valid); end
    carrier(124);
    drive(1'b0, 6); drive(1'b1, 2); carrier(1);
    checks++; if (revo_period !== 24'd508) begin failures++; $display("FAIL period_508 got=%0d want=508", revo_period); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL period_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  task automatic test_timeout();
    mism = 0; revo_seen = 0;
    carrier(2);
    drive(1'b0, 19);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL timeout_locked got=%b want=0", locked); end
    checks++; if (error_count !== 16'd1) begin failures++; $display("FAIL timeout_errors got=%0d want=1", error_count); end
    checks++; if (revo_seen !== 0) begin failures++; $display("FAIL timeout_no_revo got=%0d want=0", revo_seen); end
    carrier(12);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL timeout_relock got=%b want=1", locked); end
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL timeout_pv_cleared got=%b want=0", period_valid); end
    drive(1'b0, 6); drive(1'b1, 2); carrier(2);
    checks++; if (period_valid !== 1'b0) begin failures++; $display("FAIL timeout_pv_first got=%b want=0", period_valid); end
    checks++; if (revo_count !== 16'd5) begin failures++; $display("FAIL timeout_count got=%0d want=5", revo_count); end
    drive(1'b0, 6); drive(1'b1, 2); carrier(2);
    checks++; if (period_valid !== 1'b1) begin failures++; $display("FAIL timeout_pv_second got=%b want=1", period_valid); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL timeout_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  task automatic test_illegal_gap();
    mism = 0; revo_seen = 0;
    drive(1'b0, 4); drive(1'b1, 3);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL gap4_locked got=%b want=0", locked); end
    checks++; if (error_count !== 16'd2) begin failures++; $display("FAIL gap4_errors got=%0d want=2", error_count); end
    carrier(12);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL gap4_relock got=%b want=1", locked); end
    drive(1'b0, 9); drive(1'b1, 3);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL gap9_locked got=%b want=0", locked); end
    checks++; if (error_count !== 16'd3) begin failures++; $display("FAIL gap9_errors got=%0d want=3", error_count); end
    checks++; if (revo_count !== 16'd6 || revo_seen !== 0) begin failures++; $display("FAIL gap_revo got count=%0d pulses=%0d want 6 and 0", revo_count, revo_seen); end
    carrier(12);
    checks++; if (mism !== 0) begin failures++; $display("FAIL gap_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  task automatic test_reset_mid_marker();
    mism = 0;
    carrier(1); drive(1'b0, 3);
    #2 reset = 1'b1; model_reset();
    #1;
    checks++; if ({revo, locked, revo_count, revo_period, period_valid, error_count} !== 59'd0) begin
      failures++; $display("FAIL midreset_outputs got revo=%b locked=%b cnt=%0d per=%0d pv=%b err=%0d want all 0", revo, locked, revo_count, revo_period, period_valid, error_count); end
    drive(1'b0, 2);
    reset = 1'b0; revo_seen = 0;
    drive(1'b0, 3); drive(1'b1, 3);
    checks++; if (revo_seen !== 0 || locked !== 1'b0) begin failures++; $display("FAIL midreset_no_revo got pulses=%0d locked=%b want 0 and 0", revo_seen, locked); end
    carrier(12);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL midreset_relock got=%b want=1", locked); end
    drive(1'b0, 6); tick(1'b1); tick(1'b1); tick(1'b1);
    checks++; if (revo !== 1'b1) begin failures++; $display("FAIL inflight_strobe got=%b want=1", revo); end
    #2 reset = 1'b1; model_reset();
    #1;
    checks++; if (revo !== 1'b0 || revo_count !== 16'd0) begin failures++; $display("FAIL inflight_cleared got revo=%b cnt=%0d want 0 and 0", revo, revo_count); end
    tick(1'b0);
    reset = 1'b0;
    carrier(12);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL inflight_relock got=%b want=1", locked); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL midreset_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  task automatic test_random();
    int r, lo, hi;
    mism = 0;
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 19));
      lo = int'($urandom_range(1, 3)); hi = int'($urandom_range(1, 3));
      if (r >= 14 && r <= 16) lo = int'($urandom_range(5, 7));
      else if (r == 17) lo = ($urandom_range(0, 1) == 0) ? 4 : int'($urandom_range(8, 10));
      else if (r == 18) hi = int'($urandom_range(4, 6));
      else if (r == 19) lo = int'($urandom_range(16, 20));
      drive(1'b0, lo); drive(1'b1, hi);
    end
    checks++; if (mism !== 0) begin failures++; $display("FAIL random_trace %0d cycles differ, first: %s", mism, first_mism); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_marker();
    test_period();
    test_timeout();
    test_illegal_gap();
    test_reset_mid_marker();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
